// File: rtl/mux_reensamblador.sv
// ---------------------------------------------------------------------------
// mux_reensamblador
//
// Merges the two lanes produced by the lane demultiplexer back into a single
// ordered stream. Each lane is buffered in its own FIFO; words leave in strict
// alternation (lane 0, lane 1, lane 0, ...), so a lane that runs ahead waits
// for the other one and the original order is restored.
//
// Parameters:
//   BUS_WIDTH  width of each lane word and of data_out
//   DEPTH      entries per lane FIFO (power of 2, minimum 2)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   data_in_0  lane 0 word
//   valid_0    lane 0 push request
//   data_in_1  lane 1 word
//   valid_1    lane 1 push request
//   data_out   merged word (registered, holds between words)
//   valid_out  one-cycle strobe per emitted word (registered)
//   full_0     lane 0 FIFO holds DEPTH entries
//   full_1     lane 1 FIFO holds DEPTH entries
//   error      sticky overflow flag, cleared only by reset
// ---------------------------------------------------------------------------
module mux_reensamblador #(
    parameter int unsigned BUS_WIDTH = 4,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] data_in_0,
    input  logic                 valid_0,
    input  logic [BUS_WIDTH-1:0] data_in_1,
    input  logic                 valid_1,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic                 valid_out,
    output logic                 full_0,
    output logic                 full_1,
    output logic                 error
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    typedef enum logic {
        StEspera0 = 1'b0,
        StEspera1 = 1'b1
    } state_e;

    state_e state;

    logic [BUS_WIDTH-1:0] mem_0 [DEPTH];
    logic [BUS_WIDTH-1:0] mem_1 [DEPTH];

    logic [PW-1:0] wr_ptr_0, rd_ptr_0;
    logic [PW-1:0] wr_ptr_1, rd_ptr_1;
    logic [CW-1:0] count_0, count_1;

    logic pop_0, pop_1;
    logic push_0, push_1;
    logic overflow;

    // -----------------------------------------------------------------------
    // Push / pop decisions. Pops depend only on registered state, so there
    // is no combinational path from the inputs to data_out/valid_out.
    // A push into a full lane is still accepted when that lane is popped on
    // the same edge, since the pop frees the slot.
    // -----------------------------------------------------------------------
    always_comb begin
        full_0   = (count_0 == COUNT_FULL);
        full_1   = (count_1 == COUNT_FULL);
        pop_0    = (state == StEspera0) && (count_0 != '0);
        pop_1    = (state == StEspera1) && (count_1 != '0);
        push_0   = valid_0 && (!full_0 || pop_0);
        push_1   = valid_1 && (!full_1 || pop_1);
        overflow = (valid_0 && full_0 && !pop_0) || (valid_1 && full_1 && !pop_1);
    end

    // Storage has no reset: pointers and counts define which entries are live.
    always_ff @(posedge clk) begin
        if (push_0 && !reset) begin
            mem_0[wr_ptr_0] <= data_in_0;
        end
        if (push_1 && !reset) begin
            mem_1[wr_ptr_1] <= data_in_1;
        end
    end

    // -----------------------------------------------------------------------
    // Lane 0 FIFO bookkeeping. Pointers wrap naturally at DEPTH (power of 2).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_0 <= '0;
            rd_ptr_0 <= '0;
            count_0  <= '0;
        end else begin
            if (push_0) begin
                wr_ptr_0 <= wr_ptr_0 + PW'(1);
            end
            if (pop_0) begin
                rd_ptr_0 <= rd_ptr_0 + PW'(1);
            end
            if (push_0 && !pop_0) begin
                count_0 <= count_0 + CW'(1);
            end else if (!push_0 && pop_0) begin
                count_0 <= count_0 - CW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lane 1 FIFO bookkeeping.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_1 <= '0;
            rd_ptr_1 <= '0;
            count_1  <= '0;
        end else begin
            if (push_1) begin
                wr_ptr_1 <= wr_ptr_1 + PW'(1);
            end
            if (pop_1) begin
                rd_ptr_1 <= rd_ptr_1 + PW'(1);
            end
            if (push_1 && !pop_1) begin
                count_1 <= count_1 + CW'(1);
            end else if (!push_1 && pop_1) begin
                count_1 <= count_1 - CW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Alternation FSM with registered outputs. Only the expected lane is
    // popped; data_out holds its last value whenever nothing is emitted.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StEspera0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                StEspera0: begin
                    if (pop_0) begin
                        data_out  <= mem_0[rd_ptr_0];
                        valid_out <= 1'b1;
                        state     <= StEspera1;
                    end
                end
                StEspera1: begin
                    if (pop_1) begin
                        data_out  <= mem_1[rd_ptr_1];
                        valid_out <= 1'b1;
                        state     <= StEspera0;
                    end
                end
                default: state <= StEspera0;
            endcase
        end
    end

    // Sticky overflow: a dropped word is never recoverable, so keep the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error <= 1'b0;
        end else if (overflow) begin
            error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_reensamblador.sv
// ---------------------------------------------------------------------------
// tb_mux_reensamblador
//
// Self-checking bench for mux_reensamblador. A queue-based reference model
// (one queue per lane plus the expected-lane bit) predicts every output after
// each rising edge. Directed scenarios cover reset, alternation, order hold,
// overflow, full-with-pop and asynchronous mid-stream reset; a randomized
// phase follows.
// ---------------------------------------------------------------------------
module tb_mux_reensamblador;

    localparam int unsigned BW    = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] data_in_0, data_in_1;
    logic          valid_0, valid_1;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic          full_0, full_1;
    logic          error;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    int            m_lane;
    logic [BW-1:0] m_dout;
    logic          m_vout;
    logic          m_err;

    mux_reensamblador #(
        .BUS_WIDTH(BW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in_0(data_in_0),
        .valid_0  (valid_0),
        .data_in_1(data_in_1),
        .valid_1  (valid_1),
        .data_out (data_out),
        .valid_out(valid_out),
        .full_0   (full_0),
        .full_1   (full_1),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_lane = 0;
        m_dout = '0;
        m_vout = 1'b0;
        m_err  = 1'b0;
    endtask

    // One rising edge of the reference: pop decision uses pre-edge contents,
    // then pushes are applied (a popped lane always has room).
    task automatic model_step(input logic v0, input logic [BW-1:0] d0,
                              input logic v1, input logic [BW-1:0] d1);
        m_vout = 1'b0;
        if (m_lane == 0 && q0.size() > 0) begin
            m_dout = q0.pop_front();
            m_vout = 1'b1;
            m_lane = 1;
        end else if (m_lane == 1 && q1.size() > 0) begin
            m_dout = q1.pop_front();
            m_vout = 1'b1;
            m_lane = 0;
        end
        if (v0) begin
            if (q0.size() < DEPTH) q0.push_back(d0);
            else m_err = 1'b1;
        end
        if (v1) begin
            if (q1.size() < DEPTH) q1.push_back(d1);
            else m_err = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid_out"}, 32'(valid_out), 32'(m_vout));
        check({tag, ".data_out"},  32'(data_out),  32'(m_dout));
        check({tag, ".full_0"},    32'(full_0),    32'(q0.size() == DEPTH));
        check({tag, ".full_1"},    32'(full_1),    32'(q1.size() == DEPTH));
        check({tag, ".error"},     32'(error),     32'(m_err));
    endtask

    // Drive inputs (called 1 time unit after an edge), take an edge, check.
    task automatic cyc(input string tag, input logic v0, input logic [BW-1:0] d0,
                       input logic v1, input logic [BW-1:0] d1);
        valid_0   = v0;
        data_in_0 = v0 ? d0 : BW'($urandom);
        valid_1   = v1;
        data_in_1 = v1 ? d1 : BW'($urandom);
        @(posedge clk);
        model_step(v0, d0, v1, d1);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, '0, 1'b0, '0);
    endtask

    // Reset asserted between edges with valids high; outputs must clear at once.
    task automatic async_reset(input string tag);
        #3;
        valid_0   = 1'b1;
        valid_1   = 1'b1;
        data_in_0 = 4'hE;
        data_in_1 = 4'hD;
        reset     = 1'b1;
        #1;
        model_clear();
        check_all({tag, ".during"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        #2;
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        reset   = 1'b0;
        #2;
    endtask

    initial begin
        reset     = 1'b0;
        valid_0   = 1'b0;
        valid_1   = 1'b0;
        data_in_0 = '0;
        data_in_1 = '0;
        model_clear();
        @(posedge clk);
        #1;

        // Reset with both lanes pushing: nothing may be captured.
        async_reset("rst");
        idle("rst_idle", 2);
        check("rst.empty_first", 32'(valid_out), 32'd0);

        // Alternating stream F,3,7,A
        cyc("alt", 1'b1, 4'hF, 1'b0, '0);
        cyc("alt", 1'b0, '0, 1'b1, 4'h3);
        check("alt.first", 32'(data_out), 32'hF);
        cyc("alt", 1'b1, 4'h7, 1'b0, '0);
        cyc("alt", 1'b0, '0, 1'b1, 4'hA);
        idle("alt", 2);

        // Order hold: lane 1 alone must not be emitted while lane 0 is expected
        async_reset("rst2");
        cyc("hold", 1'b0, '0, 1'b1, 4'h5);
        cyc("hold", 1'b0, '0, 1'b1, 4'h5);
        cyc("hold", 1'b0, '0, 1'b1, 4'h5);
        check("hold.no_out", 32'(valid_out), 32'd0);
        cyc("hold", 1'b1, 4'h2, 1'b0, '0);
        idle("hold", 5);

        // Overflow on lane 1: 9 is dropped
        async_reset("rst3");
        cyc("ovf", 1'b0, '0, 1'b1, 4'h1);
        cyc("ovf", 1'b0, '0, 1'b1, 4'h2);
        cyc("ovf", 1'b0, '0, 1'b1, 4'h3);
        cyc("ovf", 1'b0, '0, 1'b1, 4'h4);
        check("ovf.full_1", 32'(full_1), 32'd1);
        check("ovf.no_err_yet", 32'(error), 32'd0);
        cyc("ovf", 1'b0, '0, 1'b1, 4'h9);
        check("ovf.error", 32'(error), 32'd1);
        for (int i = 0; i < 4; i++) cyc("ovf_drain", 1'b1, 4'h0, 1'b0, '0);
        idle("ovf_drain", 6);
        check("ovf.sticky", 32'(error), 32'd1);

        // Full lane 0 accepts a push on the edge it is popped
        async_reset("rst4");
        cyc("fullpop", 1'b1, 4'h8, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc("fullpop", 1'b1, 4'(i + 1), 1'b0, '0);
        check("fullpop.full_0", 32'(full_0), 32'd1);
        cyc("fullpop", 1'b0, '0, 1'b1, 4'hB);
        cyc("fullpop", 1'b0, '0, 1'b0, '0);
        cyc("fullpop", 1'b1, 4'hC, 1'b0, '0);
        check("fullpop.no_err", 32'(error), 32'd0);
        check("fullpop.still_full", 32'(full_0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc("fullpop_drain", 1'b0, '0, 1'b1, 4'(i + 4));
            cyc("fullpop_drain", 1'b0, '0, 1'b0, '0);
        end
        idle("fullpop_drain", 4);

        // Mid-stream reset with three words buffered
        async_reset("rst5");
        cyc("mid", 1'b0, '0, 1'b1, 4'h6);
        cyc("mid", 1'b0, '0, 1'b1, 4'h7);
        cyc("mid", 1'b0, '0, 1'b1, 4'h8);
        async_reset("mid_rst");
        idle("mid_after", 4);
        cyc("mid_after", 1'b0, '0, 1'b1, 4'h1);
        idle("mid_after", 2);

        // Randomized phase with varying lane densities and occasional resets
        for (int i = 0; i < 1200; i++) begin
            int p0, p1;
            p0 = (i < 400) ? 50 : (i < 800) ? 90 : 30;
            p1 = (i < 400) ? 50 : (i < 800) ? 85 : 70;
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            cyc("rnd", 1'($urandom_range(0, 99) < p0), BW'($urandom),
                       1'($urandom_range(0, 99) < p1), BW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_reensamblador.md
Name: mux_reensamblador

Overview:
- Re-merges the two 4-bit lanes produced by the lane demultiplexer back into a single ordered bus.
- The demux alternates words onto lane 0 and lane 1. This block buffers each lane in a small FIFO and emits words in strict alternation: lane 0, lane 1, lane 0, and so on.
- It sits downstream of the demux in the component library and restores the original stream order.
- It provides per-lane full flags and a sticky overflow error for the upstream side.

Parameters:
- BUS_WIDTH, 4, width of each lane word and of data_out.
- DEPTH, 4, entries per lane FIFO; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in_0  input  BUS_WIDTH  lane 0 word.
- valid_0  input  1  lane 0 word present this cycle (push request).
- data_in_1  input  BUS_WIDTH  lane 1 word.
- valid_1  input  1  lane 1 word present this cycle (push request).
- data_out  output  BUS_WIDTH  merged word, registered.
- valid_out  output  1  data_out holds a new word this cycle, registered.
- full_0  output  1  lane 0 FIFO holds DEPTH entries.
- full_1  output  1  lane 1 FIFO holds DEPTH entries.
- error  output  1  sticky overflow flag.

Behaviour:
Reset:
- reset=1 clears both FIFOs (pointers and counts to 0) and forces state ESPERA_0.
- Outputs under reset: data_out=0, valid_out=0, full_0=0, full_1=0, error=0.
- Reset acts immediately, without waiting for clk. Reset mid-stream discards all buffered words.

FIFOs:
- One per lane, DEPTH entries, with read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
- Pointers wrap from DEPTH-1 to 0.
- Push on valid_x at the rising edge.
- full_x is combinational from count==DEPTH.

FSM states:
- ESPERA_0: expecting lane 0. If FIFO0 is non-empty at the edge, pop its head into data_out, set valid_out=1, and go to ESPERA_1. Otherwise valid_out=0, data_out holds its value, and the state stays.
- ESPERA_1: symmetric for lane 1; go to ESPERA_0 after a pop.
- Only the expected lane is ever popped. A non-empty other lane waits, which preserves order.

Pop rate and latency:
- At most one pop per cycle.
- A word pushed at edge N into an empty FIFO whose lane is expected appears on data_out/valid_out at edge N+1.
- Sustained throughput is 1 word/cycle when both lanes keep pace.

Simultaneous push and pop (same lane, same edge):
- Both happen; the count is unchanged.
- If full, the push is accepted because the pop frees the slot.

Overflow:
- A push to a full lane that is not popped in the same edge drops the word. The FIFO contents are unchanged.
- error is set to 1 and stays 1 until reset.

Other rules:
- valid_out is 1 for exactly one cycle per emitted word. data_out changes only when valid_out=1.
- Input values while valid_x=0 are ignored.
- No combinational path from inputs to data_out/valid_out.

Test Plan:
- Reset check: reset=1 with valid_0=valid_1=1 -> data_out=0, valid_out=0, error=0, FIFOs empty after release; the first output comes from lane 0.
- Alternating stream: push lane0 'hF, lane1 'h3, lane0 'h7, lane1 'hA on consecutive edges -> data_out sequence F,3,7,A, one per cycle, each valid_out=1, first word one cycle after its push.
- Order hold: push lane1 'h5 alone for 3 cycles -> valid_out stays 0. Then push lane0 'h2 -> outputs 2, then 5.
- Overflow: with state ESPERA_0 and lane0 empty, push lane1 DEPTH+1=5 times (1,2,3,4,9) -> full_1=1 after the 4th push, error=1 after the 5th. After lane0 supplies words 0,0,0,0, output is 0,1,0,2,0,3,0,4; the value 9 never appears.
- Full with simultaneous pop: fill lane0 to 4 entries, then on the edge lane0 is popped push 'hC -> error stays 0, count stays 4, and 'hC is emitted in order later.
- Mid-operation async reset: assert reset between edges with 3 words buffered -> outputs clear immediately, state ESPERA_0, the buffered words are never emitted, and error=0.
